// File: rtl/ahb_wrr_slave_arbiter_pkg.sv
// Shared types for the weighted round-robin AHB slave-side arbiter:
// burst encoding, arbiter state encoding and the burst length helper.
package ahb_wrr_slave_arbiter_pkg;

    // AHB HBURST encoding
    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_type;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Beats in a fixed-length burst; 0 marks open-ended INCR.
    function automatic logic [4:0] burst_limit(input hburst_type b);
        logic [4:0] lim;
        case (b)
            SINGLE:         lim = 5'd1;
            WRAP4, INCR4:   lim = 5'd4;
            WRAP8, INCR8:   lim = 5'd8;
            WRAP16, INCR16: lim = 5'd16;
            default:        lim = 5'd0;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/ahb_wrr_slave_arbiter_if.sv
// Bus bundle between the competing masters and one slave-side arbiter.
// The hlock vector exists only when AHB_ARB_LOCK_EN is defined.
interface ahb_wrr_slave_arbiter_if
    import ahb_wrr_slave_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int WEIGHT_BIT = 3,
    parameter int MIDX_BIT   = $clog2(MASTER_NUM)
) ();

    logic [MASTER_NUM-1:0]                 hreq;
    hburst_type                            hburst;
    logic                                  hwait;
    logic [MASTER_NUM-1:0][WEIGHT_BIT-1:0] hweight;
`ifdef AHB_ARB_LOCK_EN
    logic [MASTER_NUM-1:0]                 hlock;
`endif
    logic [MASTER_NUM-1:0]                 hgrant;
    logic                                  hsel;
    logic [MIDX_BIT-1:0]                   hmaster;
    logic                                  hlast;

`ifdef AHB_ARB_LOCK_EN
    modport master (
        output hreq, hburst, hwait, hweight, hlock,
        input  hgrant, hsel, hmaster, hlast
    );

    modport slave (
        input  hreq, hburst, hwait, hweight, hlock,
        output hgrant, hsel, hmaster, hlast
    );
`else
    modport master (
        output hreq, hburst, hwait, hweight,
        input  hgrant, hsel, hmaster, hlast
    );

    modport slave (
        input  hreq, hburst, hwait, hweight,
        output hgrant, hsel, hmaster, hlast
    );
`endif

endinterface

// File: rtl/ahb_wrr_slave_arbiter_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// the pointer, wrapping at MASTER_NUM. The pointer is always < MASTER_NUM,
// so a single wrap subtraction is enough.
module ahb_wrr_pick #(
    parameter int MASTER_NUM = 4,
    parameter int MIDX_BIT   = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] req,
    input  logic [MASTER_NUM-1:0] credit_nz,
    input  logic [MIDX_BIT-1:0]   ptr,
    output logic [MASTER_NUM-1:0] winner,
    output logic                  any_credit
);

    logic [MASTER_NUM-1:0] cand;

    assign cand       = req & credit_nz;
    assign any_credit = |cand;

    // Scan upward from the pointer and keep the first candidate found.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < MASTER_NUM; off++) begin
            idx = int'(ptr) + off;
            if (idx >= MASTER_NUM) idx = idx - MASTER_NUM;
            if (!found && cand[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_wrr_slave_arbiter.sv
// Slave-side weighted round-robin AHB arbiter. Grant is held for a whole
// burst and handed over on the accepted final beat with no idle cycle.
// Optional feature macro: AHB_ARB_LOCK_EN (locked owner keeps the slave
// across bursts without spending credit).
module ahb_wrr_slave_arbiter
    import ahb_wrr_slave_arbiter_pkg::*;
#(
    parameter int MASTER_NUM = 4,
    parameter int WEIGHT_BIT = 3,
    parameter int MIDX_BIT   = $clog2(MASTER_NUM)
) (
    input logic                     hclk,
    input logic                     hreset_n,
    ahb_wrr_slave_arbiter_if.slave  bus
);

    localparam int         CW       = WEIGHT_BIT + 1;
    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_OWNED = OWNED;

    logic [MASTER_NUM-1:0]         grant, grant_nxt;
    logic [0:0]                    state, state_nxt;
    logic [3:0]                    count, count_nxt;
    hburst_type                    burst_r, burst_nxt;
    logic [MIDX_BIT-1:0]           ptr, ptr_post;
    logic [MASTER_NUM-1:0][CW-1:0] credit, credit_post, credit_nxt, weight_ld;

    logic [MIDX_BIT-1:0]   owner_idx, owner_inc;
    logic                  owner_req, owner_lock;
    logic                  accept, last_beat, rel_own;
    hburst_type            cur_burst;
    logic [4:0]            lim;
    logic [MASTER_NUM-1:0] credit_nz, win_cr, win_rl;
    logic                  any_credit, any_req;

    assign bus.hgrant  = grant & ~{MASTER_NUM{bus.hwait}};
    assign bus.hsel    = |grant;
    assign bus.hmaster = owner_idx;
    assign bus.hlast   = last_beat;

    assign owner_req = |(bus.hreq & grant);
`ifdef AHB_ARB_LOCK_EN
    assign owner_lock = |(bus.hlock & grant);
`else
    assign owner_lock = 1'b0;
`endif

    assign accept    = (|grant) & ~bus.hwait;
    assign cur_burst = (count == 4'd0) ? bus.hburst : burst_r;
    assign lim       = burst_limit(cur_burst);
    assign rel_own   = last_beat & ~owner_lock;
    assign owner_inc = (owner_idx == MIDX_BIT'(MASTER_NUM - 1)) ? '0 : owner_idx + 1'b1;

    // Encode the one-hot grant into the owner index (0 when idle).
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < MASTER_NUM; i++)
            if (grant[i]) owner_idx = MIDX_BIT'(i);
    end

    // Final beat: fixed bursts end at limit-1, INCR ends when the owner stops requesting.
    always_comb begin
        last_beat = 1'b0;
        if (accept) begin
            if (lim == 5'd0) last_beat = ~owner_req;
            else             last_beat = (count == 4'(lim - 5'd1));
        end
    end

    // Credits and pointer as they stand after this cycle's completion, if any.
    always_comb begin
        credit_post = credit;
        ptr_post    = ptr;
        if (rel_own) begin
            if (credit[owner_idx] != '0)
                credit_post[owner_idx] = credit[owner_idx] - CW'(1);
            if (credit_post[owner_idx] == '0) ptr_post = owner_inc;
            else                              ptr_post = owner_idx;
        end
    end

    // Eligibility vector and reload values (weight 0 counts as 1).
    always_comb begin
        credit_nz = '0;
        weight_ld = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            credit_nz[i] = |credit_post[i];
            weight_ld[i] = (bus.hweight[i] == '0) ? CW'(1) : {1'b0, bus.hweight[i]};
        end
    end

    // Credited pick: requesters that still hold credit.
    ahb_wrr_pick #(
        .MASTER_NUM (MASTER_NUM),
        .MIDX_BIT   (MIDX_BIT)
    ) u_pick_credit (
        .req        (bus.hreq),
        .credit_nz  (credit_nz),
        .ptr        (ptr_post),
        .winner     (win_cr),
        .any_credit (any_credit)
    );

    // Reload pick: every requester eligible; its flag doubles as "any request".
    ahb_wrr_pick #(
        .MASTER_NUM (MASTER_NUM),
        .MIDX_BIT   (MIDX_BIT)
    ) u_pick_reload (
        .req        (bus.hreq),
        .credit_nz  ({MASTER_NUM{1'b1}}),
        .ptr        (ptr_post),
        .winner     (win_rl),
        .any_credit (any_req)
    );

    // Ownership: arbitrate from idle or on a released final beat, else hold.
    always_comb begin
        grant_nxt  = grant;
        state_nxt  = state;
        credit_nxt = credit_post;
        if (state == ST_IDLE || rel_own) begin
            if (any_req) begin
                state_nxt = ST_OWNED;
                if (any_credit) begin
                    grant_nxt = win_cr;
                end else begin
                    grant_nxt  = win_rl;
                    credit_nxt = weight_ld;
                end
            end else begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        end
    end

    // Beat counter and burst type captured on the first accepted beat.
    always_comb begin
        count_nxt = count;
        burst_nxt = burst_r;
        if (accept && count == 4'd0) burst_nxt = bus.hburst;
        if (last_beat)   count_nxt = 4'd0;
        else if (accept) count_nxt = count + 4'd1;
    end

    // State registers.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            grant   <= '0;
            state   <= ST_IDLE;
            count   <= 4'd0;
            burst_r <= SINGLE;
            ptr     <= '0;
            credit  <= '0;
        end else begin
            grant   <= grant_nxt;
            state   <= state_nxt;
            count   <= count_nxt;
            burst_r <= burst_nxt;
            ptr     <= ptr_post;
            credit  <= credit_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_wrr_slave_arbiter.sv
// Directed bench for ahb_wrr_slave_arbiter: table vectors for the plain
// arbitration orders, hand-written sequences for waits, INCR release,
// no-preemption, mid-burst reset and (with AHB_ARB_LOCK_EN) locking.
module tb_ahb_wrr_slave_arbiter;
    import ahb_wrr_slave_arbiter_pkg::*;

    localparam int MN = 4;
    localparam int WB = 3;
    localparam int MB = 2;

    typedef struct {
        logic [3:0] req;
        hburst_type burst;
        logic       wt;
        logic       esel;
        logic [3:0] egnt;
        logic [1:0] emst;
        logic       elast;
    } vec_t;

    logic hclk = 1'b0;
    logic hreset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    always #5 hclk = ~hclk;

    ahb_wrr_slave_arbiter_if #(.MASTER_NUM(MN), .WEIGHT_BIT(WB), .MIDX_BIT(MB)) bus ();

    ahb_wrr_slave_arbiter #(.MASTER_NUM(MN), .WEIGHT_BIT(WB), .MIDX_BIT(MB)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    function automatic vec_t mk(input logic [3:0] req, input hburst_type burst, input logic wt,
                                input logic esel, input logic [3:0] egnt, input logic [1:0] emst,
                                input logic elast);
        vec_t v;
        v.req = req; v.burst = burst; v.wt = wt;
        v.esel = esel; v.egnt = egnt; v.emst = emst; v.elast = elast;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic esel, input logic [3:0] egnt,
                           input logic [1:0] emst, input logic elast);
        chk({nm, ".hsel"},    32'(bus.hsel),    32'(esel));
        chk({nm, ".hgrant"},  32'(bus.hgrant),  32'(egnt));
        chk({nm, ".hmaster"}, 32'(bus.hmaster), 32'(emst));
        chk({nm, ".hlast"},   32'(bus.hlast),   32'(elast));
    endtask

    // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic cyc(input string nm, input vec_t v);
        bus.hreq   = v.req;
        bus.hburst = v.burst;
        bus.hwait  = v.wt;
        @(negedge hclk);
        chk_out(nm, v.esel, v.egnt, v.emst, v.elast);
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset(input logic [11:0] w);
        hreset_n    = 1'b0;
        bus.hreq    = '0;
        bus.hburst  = SINGLE;
        bus.hwait   = 1'b0;
        bus.hweight = w;
`ifdef AHB_ARB_LOCK_EN
        bus.hlock   = '0;
`endif
        repeat (2) @(posedge hclk);
        #1 hreset_n = 1'b1;
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int k = lo; k < hi; k++)
            cyc($sformatf("tbl%0d", k), tbl[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a_end, b_end, c_end;
        logic w;

        // Segment A: single master, SINGLE bursts, back to idle when it stops.
        tbl.push_back(mk(4'b0000, SINGLE, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0001, SINGLE, 0, 0, 4'b0000, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(4'b0001, SINGLE, 0, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0000, SINGLE, 0, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0000, SINGLE, 0, 0, 4'b0000, 0, 0));
        a_end = tbl.size();

        // Segment B: equal weights, all requesting INCR4 -> M0,M1,M2,M3,M0.
        tbl.push_back(mk(4'b1111, INCR4, 0, 0, 4'b0000, 0, 0));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(4'b1111, INCR4, 0, 1, 4'(1 << ((k / 4) % 4)),
                             2'((k / 4) % 4), (k % 4) == 3));
        b_end = tbl.size();

        // Segment C: weights M0=2, M1=0 (acts as 1), SINGLE -> M0,M0,M1,M0,M0,M1.
        tbl.push_back(mk(4'b0011, SINGLE, 0, 0, 4'b0000, 0, 0));
        tbl.push_back(mk(4'b0011, SINGLE, 0, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0011, SINGLE, 0, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0011, SINGLE, 0, 1, 4'b0010, 1, 1));
        tbl.push_back(mk(4'b0011, SINGLE, 0, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0011, SINGLE, 0, 1, 4'b0001, 0, 1));
        tbl.push_back(mk(4'b0011, SINGLE, 0, 1, 4'b0010, 1, 1));
        c_end = tbl.size();

        do_reset({3'd1, 3'd1, 3'd1, 3'd1});
        @(negedge hclk);
        chk_out("reset", 0, 4'b0000, 0, 0);
        @(posedge hclk);
        #1;
        run_tbl(0, a_end);

        do_reset({3'd1, 3'd1, 3'd1, 3'd1});
        run_tbl(a_end, b_end);

        do_reset({3'd1, 3'd1, 3'd0, 3'd2});
        run_tbl(b_end, c_end);

        // INCR8 from M2 with waits on beats 3 and 7: 10 owned cycles, one hlast.
        do_reset({3'd1, 3'd1, 3'd1, 3'd1});
        cyc("wait.idle", mk(4'b0100, INCR8, 0, 0, 4'b0000, 0, 0));
        for (int c = 0; c < 10; c++) begin
            w = (c == 3) || (c == 8);
            cyc($sformatf("wait.c%0d", c),
                mk(4'b0100, INCR8, w, 1, w ? 4'b0000 : 4'b0100, 2, c == 9));
        end

        // Fixed burst is not preempted when the owner drops its request.
        do_reset({3'd1, 3'd1, 3'd1, 3'd1});
        cyc("npre.idle", mk(4'b0011, INCR4, 0, 0, 4'b0000, 0, 0));
        cyc("npre.b0",   mk(4'b0011, INCR4, 0, 1, 4'b0001, 0, 0));
        cyc("npre.b1",   mk(4'b0011, INCR4, 0, 1, 4'b0001, 0, 0));
        cyc("npre.b2",   mk(4'b0010, INCR4, 0, 1, 4'b0001, 0, 0));
        cyc("npre.b3",   mk(4'b0010, INCR4, 0, 1, 4'b0001, 0, 1));
        cyc("npre.m1",   mk(4'b0010, INCR4, 0, 1, 4'b0010, 1, 0));

        // INCR: owner M0 drops hreq at beat 5, M1 takes over next cycle.
        do_reset({3'd1, 3'd1, 3'd1, 3'd1});
        cyc("incr.idle", mk(4'b0011, INCR, 0, 0, 4'b0000, 0, 0));
        for (int b = 0; b < 5; b++)
            cyc($sformatf("incr.b%0d", b), mk(4'b0011, INCR, 0, 1, 4'b0001, 0, 0));
        cyc("incr.b5",  mk(4'b0010, INCR, 0, 1, 4'b0001, 0, 1));
        cyc("incr.m1a", mk(4'b0010, INCR, 0, 1, 4'b0010, 1, 0));
        cyc("incr.m1b", mk(4'b0010, INCR, 0, 1, 4'b0010, 1, 0));

        // Asynchronous reset in the middle of M1's burst.
        #2 hreset_n = 1'b0;
        #1 chk_out("arst.now", 0, 4'b0000, 0, 0);
        @(negedge hclk);
        chk_out("arst.hold", 0, 4'b0000, 0, 0);
        @(posedge hclk);
        #1 hreset_n = 1'b1;
        cyc("arst.idle", mk(4'b0010, INCR, 0, 0, 4'b0000, 0, 0));
        cyc("arst.m1",   mk(4'b0010, INCR, 0, 1, 4'b0010, 1, 0));

`ifdef AHB_ARB_LOCK_EN
        // Locked first burst keeps M0; M1 only after the unlocked second burst.
        do_reset({3'd1, 3'd1, 3'd1, 3'd1});
        bus.hlock = 4'b0001;
        cyc("lock.idle", mk(4'b0011, INCR4, 0, 0, 4'b0000, 0, 0));
        for (int b = 0; b < 4; b++)
            cyc($sformatf("lock.a%0d", b), mk(4'b0011, INCR4, 0, 1, 4'b0001, 0, b == 3));
        bus.hlock = 4'b0000;
        for (int b = 0; b < 4; b++)
            cyc($sformatf("lock.b%0d", b), mk(4'b0011, INCR4, 0, 1, 4'b0001, 0, b == 3));
        cyc("lock.m1", mk(4'b0011, INCR4, 0, 1, 4'b0010, 1, 0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
